// File: rtl/ifu_idu_inst_queue.sv
// ifu_idu_inst_queue: {pc, inst} FIFO decoupling IFU fetch from IDU decode.
// Flush drops all queued wrong-path entries; reset additionally zeroes storage.
module ifu_idu_inst_queue #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PC_W-1:0]        in_pc,
   input  logic [INST_W-1:0]      in_inst,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PC_W-1:0]        out_pc,
   output logic [INST_W-1:0]      out_inst,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [PC_W-1:0]   r_mem_pc   [DEPTH];
   logic [INST_W-1:0] r_mem_inst [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;

   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_rd_idx;
   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;

   assign w_wr_idx = r_wr_ptr[AW-1:0];
   assign w_rd_idx = r_rd_ptr[AW-1:0];

   // MSB is the wrap bit: same index with differing wrap means full
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (w_wr_idx == w_rd_idx) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);

   assign in_ready  = !w_full && !rstn;
   assign out_valid = !w_empty;
   assign out_pc    = r_mem_pc[w_rd_idx];
   assign out_inst  = r_mem_inst[w_rd_idx];
   assign count     = r_wr_ptr - r_rd_ptr;

   assign w_push = in_valid && in_ready;
   assign w_pop  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_pc[i]   <= '0;
            r_mem_inst[i] <= '0;
         end
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_mem_pc[w_wr_idx]   <= in_pc;
            r_mem_inst[w_wr_idx] <= in_inst;
            r_wr_ptr             <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_ifu_idu_inst_queue.sv
// Randomised and directed bench for ifu_idu_inst_queue.
// A queue of {pc, inst} pairs is the reference for every output each cycle.
module tb_ifu_idu_inst_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rstn;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [2:0]  count;

   ifu_idu_inst_queue #(
      .DEPTH (DEPTH),
      .PC_W  (32),
      .INST_W(32)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_pc    (in_pc),
      .in_inst  (in_inst),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pc   (out_pc),
      .out_inst (out_inst),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] q[$];
   logic [63:0] last_pop;
   int          npops;
   bit          clean;
   int          vectors;
   int          miscompares;

   function automatic void chk(input string n,
                               input logic [63:0] a,
                               input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endfunction

   task automatic compare();
      int sz;
      sz = q.size();
      chk("count", 64'(count), 64'(sz));
      chk("out_valid", 64'(out_valid), 64'(sz != 0));
      chk("in_ready", 64'(in_ready), 64'(!rstn && sz < DEPTH));
      if (sz != 0) begin
         chk("out_pc", 64'(out_pc), 64'(q[0][63:32]));
         chk("out_inst", 64'(out_inst), 64'(q[0][31:0]));
      end else if (clean) begin
         chk("zero_pc", 64'(out_pc), 64'd0);
         chk("zero_inst", 64'(out_inst), 64'd0);
      end
   endtask

   task automatic step(input logic rst, input logic fl,
                       input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy);
      bit push;
      bit pop;
      rstn      = rst;
      flush     = fl;
      in_valid  = iv;
      in_pc     = pc;
      in_inst   = inst;
      out_ready = ordy;
      push = iv && !rst && (q.size() < DEPTH);
      pop  = ordy && (q.size() > 0);
      @(posedge clk);
      if (pop && !rst) begin
         npops++;
         last_pop = q[0];
      end
      if (rst) begin
         q.delete();
         clean = 1'b1;
      end else if (fl) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back({pc, inst});
            clean = 1'b0;
         end
      end
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ordy);
   endtask

   initial begin
      int n0;
      vectors     = 0;
      miscompares = 0;
      npops       = 0;
      clean       = 1'b1;
      last_pop    = '0;
      rstn        = 1'b1;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_pc       = '0;
      in_inst     = '0;
      out_ready   = 1'b0;

      // reset / idle
      step(1'b1, 1'b0, 1'b1, 32'h1234, 32'h5678, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h1234, 32'h5678, 1'b0);
      chk("t1_inready_rst", 64'(in_ready), 64'd0);
      chk("t1_pc", 64'(out_pc), 64'd0);
      chk("t1_count", 64'(count), 64'd0);
      idle(1'b0);
      chk("t1_inready_after", 64'(in_ready), 64'd1);
      chk("t1_valid", 64'(out_valid), 64'd0);

      // fill then drain
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b0, 1'b1, 32'h80000000 + 32'(4 * i),
              32'h413 + 32'(i), 1'b0);
      chk("t2_inready_full", 64'(in_ready), 64'd0);
      chk("t2_count_full", 64'(count), 64'd4);
      step(1'b0, 1'b0, 1'b1, 32'hdead0000, 32'hbeef, 1'b0);
      chk("t2_count_hold", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t2_pop_pc", 64'(out_pc), 64'(32'h80000000 + 32'(4 * i)));
         chk("t2_pop_inst", 64'(out_inst), 64'(32'h413 + 32'(i)));
         idle(1'b1);
      end
      chk("t2_count_empty", 64'(count), 64'd0);

      // streaming
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b1, 32'h80001000 + 32'(4 * i),
              32'(i), 1'b1);
         chk("t3_count", 64'(count), 64'd1);
         chk("t3_pc", 64'(out_pc), 64'(32'h80001000 + 32'(4 * i)));
      end
      idle(1'b1);
      chk("t3_drained", 64'(out_valid), 64'd0);

      // flush drops queue and the push offered with it
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'b1, 32'h80000010 + 32'(4 * i), 32'h13, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h80000020, 32'h6f, 1'b0);
      chk("t5_count", 64'(count), 64'd0);
      chk("t5_valid", 64'(out_valid), 64'd0);
      step(1'b0, 1'b0, 1'b1, 32'h80000100, 32'h93, 1'b0);
      chk("t5_next_pc", 64'(out_pc), 64'h80000100);
      chk("t5_next_valid", 64'(out_valid), 64'd1);
      idle(1'b1);

      // flush together with a pop at count=2
      step(1'b0, 1'b0, 1'b1, 32'h80000200, 32'h1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h80000204, 32'h2, 1'b0);
      n0 = npops;
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("t6_one_pop", 64'(npops - n0), 64'd1);
      chk("t6_pop_pc", 64'(last_pop[63:32]), 64'h80000200);
      chk("t6_empty", 64'(out_valid), 64'd0);
      idle(1'b1);
      chk("t6_still_empty", 64'(out_valid), 64'd0);

      // reset mid-stream at count=3
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'b1, 32'h80000300 + 32'(4 * i), 32'h7, 1'b0);
      chk("t6_count3", 64'(count), 64'd3);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("t6_rst_count", 64'(count), 64'd0);
      chk("t6_rst_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_pc", 64'(out_pc), 64'd0);
      idle(1'b0);

      // random backpressure, flushes and occasional resets
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 1,
              $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 65,
              $urandom, $urandom,
              $urandom_range(0, 99) < 30);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
